// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding and counter sizing.
package uart_arb_pkg;

  typedef logic [7:0] byte_t;

  localparam int ST_W = 3;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GRANTED   = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  localparam int BUSY_TIMEOUT_DEF = 16;
  localparam int TMO_W_DEF        = $clog2(BUSY_TIMEOUT_DEF);

  // Width of the busy-timeout counter, which must hold BUSY_TIMEOUT-1.
  function automatic int tmo_cnt_w(input int busy_timeout);
    return (busy_timeout > 1) ? $clog2(busy_timeout) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-TX-side handshake bundle of the UART TX arbiter.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 3
);

  logic [NREQ-1:0]   req_valid_i;
  logic [8*NREQ-1:0] req_data_i;
  logic [NREQ-1:0]   req_last_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ-1:0]   grant_o;
  logic              tx_start_o;
  byte_t             tx_data_o;
  logic              tx_ready_i;
  logic              busy_o;

  modport master (
    input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
    output req_ready_o, grant_o, tx_start_o, tx_data_o, busy_o
  );

  modport slave (
    output req_valid_i, req_data_i, req_last_i, tx_ready_i,
    input  req_ready_o, grant_o, tx_start_o, tx_data_o, busy_o
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping at NREQ.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    k       = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
      k = sum[IDX_W-1:0];
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART transmitter among NREQ byte producers.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  uart_tx_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = tmo_cnt_w(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  logic [ST_W-1:0]  state_q;
  logic [NREQ-1:0]  grant_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             last_q;
  logic             tx_start_q;
  byte_t            tx_data_q;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  logic             owner_valid;
  logic             owner_last;
  byte_t            owner_data;
  logic             accept;
  logic [CNT_W-1:0] tmo_cnt_inc;
  logic [IDX_W-1:0] ptr_next;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (bus.req_valid_i),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign owner_valid = bus.req_valid_i[owner_q];
  assign owner_last  = bus.req_last_i[owner_q];
  assign owner_data  = bus.req_data_i[int'(owner_q)*8 +: 8];

  // The pop strobe is combinational so the producer sees it in the cycle the byte is latched.
  assign accept      = (state_q == ST_GRANTED) && owner_valid && bus.tx_ready_i;
  assign tmo_cnt_inc = tmo_cnt_q + CNT_W'(1);
  assign ptr_next    = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);

  assign bus.req_ready_o = accept ? grant_q : '0;
  assign bus.grant_o     = grant_q;
  assign bus.tx_start_o  = tx_start_q;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.busy_o      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      tmo_cnt_q  <= '0;
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_q <= arb_gnt;
            owner_q <= arb_idx;
            state_q <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          // The grant is held through valid gaps; only the last byte releases it.
          if (accept) begin
            tx_data_q  <= owner_data;
            last_q     <= owner_last;
            tx_start_q <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          tmo_cnt_q <= '0;
          state_q   <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // A TX core that never reports busy must not stall the stream forever.
          if (!bus.tx_ready_i) begin
            state_q <= ST_WAIT_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_inc;
            if (tmo_cnt_inc == TMO_LAST) state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.tx_ready_i) begin
            if (last_q) begin
              grant_q <= '0;
              ptr_q   <= ptr_next;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_GRANTED;
            end
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a byte-stream producer model and a UART TX model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NREQ    = 3;
  localparam int BT      = 16;
  localparam int TX_BUSY = 10;
  localparam int MAXB    = 8;
  localparam int MAXLOG  = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ         (NREQ),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]      smem  [NREQ][MAXB];
  logic            slast [NREQ][MAXB];
  int              slen  [NREQ];
  int              rd_idx[NREQ];
  logic            gap   [NREQ];
  int              pop_cnt[NREQ];
  logic            tx_drop;
  int              tx_busy;
  int              cyc;
  logic [7:0]      log_data[MAXLOG];
  logic [NREQ-1:0] log_gnt [MAXLOG];
  int              log_cyc [MAXLOG];
  int              log_n;
  logic [NREQ-1:0] ord[MAXLOG];
  int              ord_n;
  logic [NREQ-1:0] prev_grant;
  int              first_pop_cyc;
  int              viol;

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (rd_idx[i] < slen[i]) begin
        bus.req_valid_i[i]       = !gap[i];
        bus.req_data_i[8*i +: 8] = smem[i][rd_idx[i]];
        bus.req_last_i[i]        = slast[i][rd_idx[i]];
      end else begin
        bus.req_valid_i[i]       = 1'b0;
        bus.req_data_i[8*i +: 8] = 8'h00;
        bus.req_last_i[i]        = 1'b0;
      end
    end
  endtask

  task automatic clear_logs();
    log_n = 0; ord_n = 0; prev_grant = '0; first_pop_cyc = -1; viol = 0;
    for (int i = 0; i < NREQ; i++) pop_cnt[i] = 0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) begin
      slen[i] = 0; rd_idx[i] = 0; gap[i] = 1'b0;
    end
    tx_busy = 0; tx_drop = 1'b1; bus.tx_ready_i = 1'b1;
    clear_logs();
    drive_inputs();
  endtask

  task automatic load_stream(input int r, input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input logic [3:0] lmask);
    logic [7:0] b[4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int k = 0; k < 4; k++) begin
      smem[r][k]  = b[k];
      slast[r][k] = lmask[k];
    end
    slen[r] = n; rd_idx[r] = 0;
    drive_inputs();
  endtask

  // One clock: observe at the falling edge, update the models just after the rising edge.
  task automatic step();
    logic [NREQ-1:0] pops;
    @(negedge clk);
    pops = bus.req_ready_o;
    if (bus.tx_start_o) begin
      if (log_n < MAXLOG) begin
        log_data[log_n] = bus.tx_data_o;
        log_gnt[log_n]  = bus.grant_o;
        log_cyc[log_n]  = cyc;
        log_n++;
      end
      if (tx_drop) tx_busy = TX_BUSY;
    end
    if (pops != '0 && first_pop_cyc < 0) first_pop_cyc = cyc;
    if (((pops & ~bus.grant_o) != '0) || !$onehot0(pops) || !$onehot0(bus.grant_o)) viol++;
    if (bus.grant_o != '0 && prev_grant == '0 && ord_n < MAXLOG) begin
      ord[ord_n] = bus.grant_o;
      ord_n++;
    end
    prev_grant = bus.grant_o;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (pops[i]) begin
        rd_idx[i]++;
        pop_cnt[i]++;
      end
    end
    if (tx_busy > 0) begin
      bus.tx_ready_i = 1'b0;
      tx_busy--;
    end else begin
      bus.tx_ready_i = 1'b1;
    end
    drive_inputs();
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    clear_model();
    repeat (3) step();
    rstn = 1'b1;
  endtask

  task automatic run_until_idle(input int max_cyc, output bit to);
    bit done;
    to = 1'b1;
    for (int n = 0; n < max_cyc; n++) begin
      step();
      done = !bus.busy_o;
      for (int i = 0; i < NREQ; i++) if (rd_idx[i] < slen[i]) done = 1'b0;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_dut();
    n_tests++; if (bus.grant_o !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", bus.grant_o); end
    n_tests++; if (bus.req_ready_o !== 3'b000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 000", bus.req_ready_o); end
    n_tests++; if (bus.tx_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start_o); end
    n_tests++; if (bus.tx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data_o); end
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_single_packet();
    bit to;
    logic [7:0] exp_b[3];
    exp_b = '{8'h4F, 8'h4B, 8'h0A};
    reset_dut();
    load_stream(0, 3, 8'h4F, 8'h4B, 8'h0A, 8'h00, 4'b0100);
    run_until_idle(400, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b want 0", to); end
    n_tests++; if (log_n != 3) begin n_fail++; $display("FAIL single_start_count: got %0d want 3", log_n); end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (log_data[k] !== exp_b[k] || log_gnt[k] !== 3'b001) begin
        n_fail++; $display("FAIL single_byte%0d: got %h/%b want %h/001", k, log_data[k], log_gnt[k], exp_b[k]);
      end
    end
    n_tests++; if (pop_cnt[0] != 3) begin n_fail++; $display("FAIL single_pops: got %0d want 3", pop_cnt[0]); end
    n_tests++; if (bus.grant_o !== 3'b000) begin n_fail++; $display("FAIL single_grant_release: got %b want 000", bus.grant_o); end
    n_tests++; if (log_cyc[0] != first_pop_cyc + 1) begin n_fail++; $display("FAIL single_start_latency: got %0d want %0d", log_cyc[0], first_pop_cyc + 1); end
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL single_onehot: got %0d want 0", viol); end
  endtask

  task automatic test_contention();
    bit to;
    logic [7:0]      exp_b[6];
    logic [NREQ-1:0] exp_o[3];
    exp_b = '{8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32};
    exp_o = '{3'b001, 3'b010, 3'b100};
    reset_dut();
    load_stream(0, 2, 8'h11, 8'h12, 8'h00, 8'h00, 4'b0010);
    load_stream(1, 2, 8'h21, 8'h22, 8'h00, 8'h00, 4'b0010);
    load_stream(2, 2, 8'h31, 8'h32, 8'h00, 8'h00, 4'b0010);
    run_until_idle(600, to);
    n_tests++; if (to !== 1'b0 || log_n != 6) begin n_fail++; $display("FAIL contention_done: got to=%b n=%0d want to=0 n=6", to, log_n); end
    for (int k = 0; k < 6; k++) begin
      n_tests++; if (log_data[k] !== exp_b[k]) begin n_fail++; $display("FAIL contention_byte%0d: got %h want %h", k, log_data[k], exp_b[k]); end
    end
    n_tests++; if (ord_n != 3) begin n_fail++; $display("FAIL contention_grants: got %0d want 3", ord_n); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (ord[k] !== exp_o[k]) begin n_fail++; $display("FAIL contention_order%0d: got %b want %b", k, ord[k], exp_o[k]); end
    end
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL contention_onehot: got %0d want 0", viol); end
    // Pointer should have wrapped to 0: req0 beats req1 in a tie.
    clear_logs();
    load_stream(1, 1, 8'h55, 8'h00, 8'h00, 8'h00, 4'b0001);
    load_stream(0, 1, 8'h66, 8'h00, 8'h00, 8'h00, 4'b0001);
    run_until_idle(300, to);
    n_tests++; if (ord[0] !== 3'b001 || log_data[0] !== 8'h66) begin n_fail++; $display("FAIL contention_ptr_wrap: got %b/%h want 001/66", ord[0], log_data[0]); end
  endtask

  task automatic test_fairness();
    bit to;
    logic [7:0]      exp_b[6];
    logic [NREQ-1:0] exp_o[3];
    exp_b = '{8'hA1, 8'hA2, 8'hC1, 8'hC2, 8'hB1, 8'hB2};
    exp_o = '{3'b001, 3'b100, 3'b001};
    reset_dut();
    load_stream(0, 4, 8'hA1, 8'hA2, 8'hB1, 8'hB2, 4'b1010);
    load_stream(2, 2, 8'hC1, 8'hC2, 8'h00, 8'h00, 4'b0010);
    run_until_idle(600, to);
    n_tests++; if (to !== 1'b0 || log_n != 6) begin n_fail++; $display("FAIL fair_done: got to=%b n=%0d want to=0 n=6", to, log_n); end
    for (int k = 0; k < 6; k++) begin
      n_tests++; if (log_data[k] !== exp_b[k]) begin n_fail++; $display("FAIL fair_byte%0d: got %h want %h", k, log_data[k], exp_b[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (ord[k] !== exp_o[k]) begin n_fail++; $display("FAIL fair_order%0d: got %b want %b", k, ord[k], exp_o[k]); end
    end
  endtask

  task automatic test_valid_gap();
    bit to;
    int held_bad;
    int n;
    logic [7:0] exp_b[4];
    exp_b = '{8'hD1, 8'hD2, 8'hD3, 8'hE1};
    held_bad = 0;
    reset_dut();
    load_stream(0, 3, 8'hD1, 8'hD2, 8'hD3, 8'h00, 4'b0100);
    load_stream(1, 1, 8'hE1, 8'h00, 8'h00, 8'h00, 4'b0001);
    n = 0;
    while (pop_cnt[0] == 0 && n < 100) begin
      step();
      n++;
    end
    n_tests++; if (pop_cnt[0] != 1) begin n_fail++; $display("FAIL gap_first_pop: got %0d want 1", pop_cnt[0]); end
    gap[0] = 1'b1;
    drive_inputs();
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.grant_o !== 3'b001) held_bad++;
    end
    n_tests++; if (held_bad != 0) begin n_fail++; $display("FAIL gap_grant_held: got %0d bad cycles want 0", held_bad); end
    n_tests++; if (pop_cnt[1] != 0) begin n_fail++; $display("FAIL gap_no_pop_req1: got %0d want 0", pop_cnt[1]); end
    gap[0] = 1'b0;
    drive_inputs();
    run_until_idle(400, to);
    n_tests++; if (to !== 1'b0 || log_n != 4) begin n_fail++; $display("FAIL gap_done: got to=%b n=%0d want to=0 n=4", to, log_n); end
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (log_data[k] !== exp_b[k]) begin n_fail++; $display("FAIL gap_byte%0d: got %h want %h", k, log_data[k], exp_b[k]); end
    end
    n_tests++; if (ord[0] !== 3'b001 || ord[1] !== 3'b010) begin n_fail++; $display("FAIL gap_order: got %b,%b want 001,010", ord[0], ord[1]); end
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL gap_onehot: got %0d want 0", viol); end
  endtask

  task automatic test_timeout();
    bit to;
    reset_dut();
    tx_drop = 1'b0;
    load_stream(2, 3, 8'h71, 8'h72, 8'h73, 8'h00, 4'b0100);
    run_until_idle(300, to);
    n_tests++; if (to !== 1'b0 || log_n != 3) begin n_fail++; $display("FAIL tmo_done: got to=%b n=%0d want to=0 n=3", to, log_n); end
    n_tests++; if (log_cyc[1] - log_cyc[0] != BT + 2) begin n_fail++; $display("FAIL tmo_spacing01: got %0d want %0d", log_cyc[1] - log_cyc[0], BT + 2); end
    n_tests++; if (log_cyc[2] - log_cyc[1] != BT + 2) begin n_fail++; $display("FAIL tmo_spacing12: got %0d want %0d", log_cyc[2] - log_cyc[1], BT + 2); end
    n_tests++; if (log_data[0] !== 8'h71 || log_data[1] !== 8'h72 || log_data[2] !== 8'h73) begin
      n_fail++; $display("FAIL tmo_bytes: got %h %h %h want 71 72 73", log_data[0], log_data[1], log_data[2]);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    reset_dut();
    load_stream(0, 1, 8'h77, 8'h00, 8'h00, 8'h00, 4'b0001);
    run_until_idle(200, to);
    load_stream(1, 2, 8'h81, 8'h82, 8'h00, 8'h00, 4'b0010);
    n = 0;
    while (log_n < 2 && n < 100) begin
      step();
      n++;
    end
    n_tests++; if (log_n != 2 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_wait: got n=%0d busy=%b want n=2 busy=1", log_n, bus.busy_o); end
    #2;
    rstn = 1'b0;
    #1;
    n_tests++; if (bus.grant_o !== 3'b000) begin n_fail++; $display("FAIL rstmid_grant: got %b want 000", bus.grant_o); end
    n_tests++; if (bus.req_ready_o !== 3'b000) begin n_fail++; $display("FAIL rstmid_req_ready: got %b want 000", bus.req_ready_o); end
    n_tests++; if (bus.tx_data_o !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx_data: got %h want 00", bus.tx_data_o); end
    n_tests++; if (bus.busy_o !== 1'b0 || bus.tx_start_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_start: got %b/%b want 0/0", bus.busy_o, bus.tx_start_o); end
    clear_model();
    load_stream(1, 2, 8'h81, 8'h82, 8'h00, 8'h00, 4'b0010);
    load_stream(0, 1, 8'h99, 8'h00, 8'h00, 8'h00, 4'b0001);
    repeat (2) step();
    rstn = 1'b1;
    run_until_idle(400, to);
    n_tests++; if (to !== 1'b0 || log_n != 3) begin n_fail++; $display("FAIL rstmid_done: got to=%b n=%0d want to=0 n=3", to, log_n); end
    n_tests++; if (ord[0] !== 3'b001 || log_data[0] !== 8'h99) begin n_fail++; $display("FAIL rstmid_restart_req0: got %b/%h want 001/99", ord[0], log_data[0]); end
    n_tests++; if (log_data[1] !== 8'h81 || log_data[2] !== 8'h82) begin n_fail++; $display("FAIL rstmid_req1_bytes: got %h %h want 81 82", log_data[1], log_data[2]); end
  endtask

  initial begin
    cyc = 0;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
    bus.tx_ready_i  = 1'b1;
    test_reset();
    test_single_packet();
    test_contention();
    test_fairness();
    test_valid_gap();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NREQ byte-stream requesters, such as the welcome-message streamer, the scan-chain dump formatter and the status/echo path.
- Arbitrates round-robin at packet granularity: once granted, a requester keeps the transmitter until its byte flagged "last" is sent.
- Drives the transmitter's tx_start_o/tx_data_o handshake and confirms each byte completed via tx_ready_i before moving on.
- Sits between the command parser's producers and the UART TX core.

Parameters:
- NREQ, 3, number of requesters (2..8).
- BUSY_TIMEOUT, 16, max clk cycles to wait for tx_ready_i to drop after a start pulse; if it never drops, the byte is treated as sent.

Ports:
- clk  in  1  system clock (50 MHz).
- rstn  in  1  reset; asynchronous, active-low.
- req_valid_i  in  NREQ  requester i has a byte available.
- req_data_i  in  8*NREQ  byte of requester i at bits [8i+7:8i].
- req_last_i  in  NREQ  byte of requester i ends its packet.
- req_ready_o  out  NREQ  one-hot pop strobe: byte of requester i accepted this cycle.
- grant_o  out  NREQ  one-hot current owner; 0 when idle.
- tx_start_o  out  1  one-cycle start pulse to the UART TX.
- tx_data_o  out  8  byte to transmit; stable from start until the next accept.
- tx_ready_i  in  1  UART TX idle/ready.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rstn=0): state IDLE; grant_o=0; req_ready_o=0; tx_start_o=0; tx_data_o=8'h00; busy_o=0; rr pointer=0; timeout counter=0; last flag=0.
- States are IDLE, GRANTED, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If |req_valid_i, pick the first requester with valid set, searching from the pointer upward with wrap-around (NREQ-1 wraps to 0).
  - grant_o is registered one-hot to the winner; go to GRANTED.
  - Arbitration takes 1 cycle.
- GRANTED (owner g):
  - If req_valid_i[g] && tx_ready_i: req_ready_o[g]=1, combinational and in this cycle only.
  - In the same edge, register tx_data_o <= req_data_i[g] and last flag <= req_last_i[g]; go to START.
  - Otherwise wait. The grant is held even if valid drops mid-packet; there is no preemption.
- START: tx_start_o=1 for exactly this cycle, registered; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - If tx_ready_i=0, go to WAIT_DONE.
  - Otherwise increment the counter. When counter == BUSY_TIMEOUT-1, go to WAIT_DONE (byte deemed sent).
- WAIT_DONE:
  - When tx_ready_i=1:
    - If last flag: grant_o=0, pointer=(g+1) mod NREQ, go to IDLE.
    - Else go to GRANTED.
- Latency: at most one accepted byte per UART frame. From the accept cycle, tx_start_o follows 1 cycle later.
- req_ready_o is never asserted for a non-owner. At most one bit of req_ready_o is high, and at most one bit of grant_o.
- A single-byte packet (last=1 on the first byte) behaves like a complete packet.
- Simultaneous valid on all requesters: strict rotation at packet boundaries, so each requester waits at most NREQ-1 packets.
- A requester that raises valid while another owns the grant is serviced only after that owner's last byte.
- tx_ready_i low in IDLE: arbitration still grants, and the owner waits in GRANTED.
- Reset mid-packet: all state discarded. Partial packets are not resumed; the producer must restart.

Decomposition:
- Shared package uart_arb_pkg holds:
  - state encoding localparams (IDLE=0 .. WAIT_DONE=4, 3-bit);
  - the timeout counter width $clog2(BUSY_TIMEOUT).
- One sub-module, rr_arbiter:
  - purely combinational;
  - inputs: req vector and pointer; output: one-hot winner and its index.
  - The pointer register stays in uart_tx_arbiter.

Test Plan:
- Single requester: req0 sends 3-byte packet "OK\n" with the TX model holding ready low for 10 cycles per byte → three tx_start_o pulses carrying 0x4F, 0x4B, 0x0A; req_ready_o[0] pulses 3 times; grant_o returns to 0 after 0x0A.
- Contention: all three valid, each with a 2-byte packet, pointer=0 → grant order 0, 1, 2; no interleaving of bytes between packets; final pointer=0.
- Fairness: req0 re-asserts a new packet immediately after finishing while req2 is waiting → req2 is granted before req0.
- Valid gap: owner drops valid for 20 cycles mid-packet while req1 is valid → grant stays on the owner and req1 gets no req_ready_o; the packet resumes when valid returns.
- Timeout: TX model never drops ready → tx_start_o spacing = 1 + BUSY_TIMEOUT + 1 cycles; all bytes are still delivered.
- Reset: rstn low during WAIT_BUSY → all outputs 0 immediately (async); after release, arbitration starts from req0.
